// File: rtl/divider_m_n_bits_seq.sv
// ============================================================================
// divider_m_n_bits_seq
// Sequential unsigned restoring divider, one quotient bit per clock.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_m_n_bits_seq #(
  parameter int M = 10,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] num1,
  input  logic [N-1:0] num2,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(M + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after M shifts this register holds the complete quotient.
  logic [M-1:0]  shreg;
  logic [N-1:0]  divisor;
  // The restored remainder is always below the divisor, so N bits suffice.
  logic [N-1:0]  part_rem;
  logic [CW-1:0] count;

  logic [N:0]    pr;
  logic          ge;
  logic [N-1:0]  diff;
  logic [N-1:0]  next_rem;
  logic [M-1:0]  next_shreg;

  always_comb begin
    pr         = {part_rem, shreg[M-1]};
    ge         = (pr >= {1'b0, divisor});
    // Only used when pr >= divisor, where the true difference fits in N bits.
    diff       = pr[N-1:0] - divisor;
    next_rem   = ge ? diff : pr[N-1:0];
    next_shreg = {shreg[M-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shreg       <= '0;
      divisor     <= '0;
      part_rem    <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            shreg    <= num1;
            divisor  <= num2;
            part_rem <= '0;
            count    <= CW'(M);
            busy     <= 1'b1;
            state    <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end

        S_BUSY: begin
          if (divisor == '0) begin
            Quotient    <= '1;
            Remainder   <= '0;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            part_rem <= next_rem;
            shreg    <= next_shreg;
            count    <= count - CW'(1);
            if (count == CW'(1)) begin
              Quotient    <= next_shreg;
              Remainder   <= next_rem;
              div_by_zero <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
